// File: rtl/capture_ctrl.sv
// capture_ctrl: sample-rate divider, valid/ready capture stage and
// arm -> trigger -> post-trigger -> flush sequencer for the logic analyzer.
// Every output is driven directly from a flop.
module capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sync_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             trg_i,
  output logic             smpl_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Configuration latched at arm time so later cfg changes do not disturb a run
  logic [DIV_W-1:0] div_q_reg, div_q_next;
  logic [CNT_W-1:0] dly_q_reg, dly_q_next;

  // Divider down-counter and post-trigger capture counter
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [CNT_W-1:0] post_cnt_reg, post_cnt_next;
  logic [CNT_W-1:0] post_inc;

  // Output stage
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ovf_reg, ovf_next;
  logic             smpl_reg, smpl_next;
  logic             done_reg, done_next;
  logic             armed_reg, armed_next;
  logic             busy_reg, busy_next;

  // A strobe can be stored when the output slot is empty or being emptied now
  logic             capture_ok;
  logic             sampling_next;

  // smpl_reg is only ever high in ARMED/POST, so it doubles as the live strobe
  assign capture_ok = smpl_reg && (!valid_reg || ready_i);
  assign post_inc   = post_cnt_reg + CNT_W'(1);

  // State register and all output/datapath flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      div_q_reg    <= '0;
      dly_q_reg    <= '0;
      div_cnt_reg  <= '0;
      post_cnt_reg <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      smpl_reg     <= 1'b0;
      done_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_q_reg    <= div_q_next;
      dly_q_reg    <= dly_q_next;
      div_cnt_reg  <= div_cnt_next;
      post_cnt_reg <= post_cnt_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
      smpl_reg     <= smpl_next;
      done_reg     <= done_next;
      armed_reg    <= armed_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state, divider, capture and handshake logic
  always_comb begin
    state_next    = state_reg;
    div_q_next    = div_q_reg;
    dly_q_next    = dly_q_reg;
    div_cnt_next  = div_cnt_reg;
    post_cnt_next = post_cnt_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;

    // The consumer took the held sample; a capture below may refill the slot
    if (valid_reg && ready_i) begin
      valid_next = 1'b0;
    end

    unique case (state_reg)
      ST_IDLE: begin
        // abort_i is ignored here, so a simultaneous arm simply wins
        if (arm_i) begin
          div_q_next    = cfg_div_i;
          dly_q_next    = cfg_delay_i;
          div_cnt_next  = '0;
          post_cnt_next = '0;
          ovf_next      = 1'b0;
          state_next    = ST_ARMED;
        end
      end

      ST_ARMED, ST_POST: begin
        if (smpl_reg) begin
          div_cnt_next = div_q_reg;
          if (capture_ok) begin
            data_next  = sync_i;
            valid_next = 1'b1;
          end else begin
            ovf_next = 1'b1;
          end
        end else begin
          div_cnt_next = div_cnt_reg - DIV_W'(1);
        end

        if (state_reg == ST_ARMED) begin
          // The trigger sample itself is stored but never counted
          if (smpl_reg && trg_i) begin
            state_next = (dly_q_reg == '0) ? ST_FLUSH : ST_POST;
          end
        end else begin
          // Only samples that actually reach the output count toward the delay
          if (capture_ok) begin
            post_cnt_next = post_inc;
            if (post_inc == dly_q_reg) begin
              state_next = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        // Divider is frozen; wait for the last sample to leave
        if (!valid_reg || ready_i) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including arm_i
    if (abort_i && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      valid_next = 1'b0;
      data_next  = data_reg;
      ovf_next   = ovf_reg;
      done_next  = 1'b0;
    end
  end

  // Registered status outputs are derived from where the FSM is heading
  always_comb begin
    sampling_next = (state_next == ST_ARMED) || (state_next == ST_POST);
    smpl_next     = sampling_next && (div_cnt_next == '0);
    armed_next    = (state_next == ST_ARMED);
    busy_next     = (state_next != ST_IDLE);
  end

  assign smpl_o  = smpl_reg;
  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign armed_o = armed_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed steps with a data scoreboard for capture_ctrl.
module tb_capture_ctrl;

  localparam int WIDTH = 32;
  localparam int DIV_W = 24;
  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [WIDTH-1:0] sync_i = '0;
  logic [DIV_W-1:0] cfg_div_i = '0;
  logic [CNT_W-1:0] cfg_delay_i = '0;
  logic             arm_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             trg_i = 1'b0;
  logic             ready_i = 1'b1;
  logic             smpl_o;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             armed_o;
  logic             busy_o;
  logic             done_o;
  logic             ovf_o;

  int               vectors = 0;
  int               miscompares = 0;
  string            cur_test = "reset";
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] first_val;

  capture_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sync_i(sync_i), .cfg_div_i(cfg_div_i),
    .cfg_delay_i(cfg_delay_i), .arm_i(arm_i), .abort_i(abort_i), .trg_i(trg_i),
    .smpl_o(smpl_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .armed_o(armed_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%b expected=%b", cur_test, tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One cycle: check strobe/done, drive a fresh probe word, optionally expect it
  task automatic step(input logic exp_smpl, input logic push, input logic trg);
    chk1("smpl", smpl_o, exp_smpl);
    chk1("no_done", done_o, 1'b0);
    sync_i = $urandom();
    trg_i  = trg;
    if (push) sb.push_back(sync_i);
    tick();
    trg_i = 1'b0;
  endtask

  task automatic arm(input logic [DIV_W-1:0] div, input logic [CNT_W-1:0] dly);
    cfg_div_i   = div;
    cfg_delay_i = dly;
    arm_i       = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  // Scoreboard: every accepted beat must match the oldest expected sample
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL %s/sb_underflow observed=%0h expected=none", cur_test, data_o);
      end
      if (sb.size() > 0) chkw("data", data_o, sb.pop_front());
    end
  end

  initial begin
    #50000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk1("smpl", smpl_o, 1'b0);
    chkw("data", data_o, 32'd0);
    chk1("valid", valid_o, 1'b0);
    chk1("armed", armed_o, 1'b0);
    chk1("busy", busy_o, 1'b0);
    chk1("done", done_o, 1'b0);
    chk1("ovf", ovf_o, 1'b0);
    rst_i = 1'b0;
    tick();
    chk1("idle_busy", busy_o, 1'b0);

    // Basic capture: div=0, delay=3, trigger on 5th strobe
    cur_test = "basic";
    arm(24'd0, 16'd3);
    chk1("busy", busy_o, 1'b1);
    chk1("ovf", ovf_o, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      chk1("armed", armed_o, (k <= 5));
      step(1'b1, 1'b1, (k == 5));
    end
    chk1("flush_smpl", smpl_o, 1'b0);
    chk1("flush_busy", busy_o, 1'b1);
    chk1("flush_done", done_o, 1'b0);
    tick();
    chk1("done", done_o, 1'b1);
    chk1("busy_fall", busy_o, 1'b0);
    chk1("ovf", ovf_o, 1'b0);
    tick();
    chk1("done_pulse", done_o, 1'b0);
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    // Divider: div=3, cfg change after arm must be ignored, delay=2
    cur_test = "divider";
    repeat (3) tick();
    arm(24'd3, 16'd2);
    cfg_div_i = 24'd0;
    for (int j = 0; j <= 16; j++) begin
      step((j % 4 == 0), (j % 4 == 0), (j == 8));
    end
    chk1("flush_smpl", smpl_o, 1'b0);
    tick();
    chk1("done", done_o, 1'b1);
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: ready low for 4 cycles, trigger on first strobe, delay=2
    cur_test = "backpressure";
    tick();
    arm(24'd0, 16'd2);
    for (int k = 1; k <= 6; k++) begin
      ready_i = (k >= 5);
      if (k >= 2 && k <= 5) begin
        chkw("hold", data_o, first_val);
        chk1("valid", valid_o, 1'b1);
      end
      if (k == 2) chk1("ovf_clear", ovf_o, 1'b0);
      if (k == 3) chk1("ovf_set", ovf_o, 1'b1);
      step(1'b1, (k == 1 || k >= 5), (k == 1));
      if (k == 1) first_val = sync_i;
    end
    chk1("flush_smpl", smpl_o, 1'b0);
    tick();
    chk1("done", done_o, 1'b1);
    chk1("ovf_sticky", ovf_o, 1'b1);
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    // delay=0: trigger on first strobe goes straight to FLUSH
    cur_test = "delay0";
    tick();
    arm(24'd0, 16'd0);
    chk1("ovf_cleared", ovf_o, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk1("armed", armed_o, 1'b0);
    chk1("busy", busy_o, 1'b1);
    chk1("smpl", smpl_o, 1'b0);
    tick();
    chk1("done", done_o, 1'b1);
    chk1("busy", busy_o, 1'b0);
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    // Abort in POST (with a competing arm): back to IDLE, no done
    cur_test = "abort_post";
    tick();
    arm(24'd0, 16'd5);
    step(1'b1, 1'b1, 1'b1);
    ready_i = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    abort_i = 1'b1;
    arm_i   = 1'b1;
    cfg_div_i = 24'd0;
    tick();
    abort_i = 1'b0;
    arm_i   = 1'b0;
    chk1("valid", valid_o, 1'b0);
    chk1("busy", busy_o, 1'b0);
    chk1("armed", armed_o, 1'b0);
    chk1("smpl", smpl_o, 1'b0);
    sb.delete();
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk1("no_done", done_o, 1'b0);
      tick();
    end

    // arm+abort in IDLE arms; arm while ARMED is ignored
    cur_test = "arm_conflict";
    abort_i = 1'b1;
    arm(24'd2, 16'd1);
    abort_i = 1'b0;
    chk1("armed", armed_o, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    arm_i = 1'b1;
    cfg_div_i = 24'd0;
    cfg_delay_i = 16'd0;
    step(1'b0, 1'b0, 1'b0);
    arm_i = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk1("armed", armed_o, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk1("post", armed_o, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk1("flush_smpl", smpl_o, 1'b0);
    tick();
    chk1("done", done_o, 1'b1);
    chkw("sb_empty", 32'(sb.size()), 32'd0);

    // Async reset mid-POST, asserted between clock edges
    cur_test = "async_reset";
    tick();
    arm(24'd0, 16'd10);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    sync_i = $urandom();
    #3;
    rst_i = 1'b1;
    #1;
    chk1("smpl", smpl_o, 1'b0);
    chkw("data", data_o, 32'd0);
    chk1("valid", valid_o, 1'b0);
    chk1("armed", armed_o, 1'b0);
    chk1("busy", busy_o, 1'b0);
    chk1("done", done_o, 1'b0);
    chk1("ovf", ovf_o, 1'b0);
    sb.delete();
    #12;
    rst_i = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk1("idle_busy", busy_o, 1'b0);
      chk1("idle_done", done_o, 1'b0);
      tick();
    end
    arm(24'd1, 16'd1);
    chk1("rearm_armed", armed_o, 1'b1);
    chk1("rearm_smpl", smpl_o, 1'b1);
    sb.push_back(sync_i);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    sb.delete();
    chk1("final_idle", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
